isa_width_sequencer: RTL and testbench
======================================

Name: isa_width_sequencer

Overview:
- Card-side ISA I/O cycle sequencer. It sits between the ISA address decode/synchroniser logic and the internal 16-bit register bus.
- Uses the slot-width result (enable_high_byte) to do one of two things:
  - AT slot: run native 16-bit transfers with IOCS16# signalling.
  - XT slot: pair consecutive 8-bit host cycles into single 16-bit internal accesses.
- Stalls the host through IOCHRDY while the internal bus responds. Recovers from a lost ack with a timeout.

Parameters:
- ADDR_W, 4, ISA I/O offset width in bytes; internal word address is ADDR_W-1 bits.
- ACK_TIMEOUT, 255, max clk cycles waiting for reg_ack before forced completion.
- TMO_W, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable_high_byte  in  1  1=AT 16-bit slot, 0=XT 8-bit slot (from slot detection)
- io_sel  in  1  synchronised address-decode hit for this card's I/O window
- io_rd  in  1  synchronised IOR# active (level, high=active)
- io_wr  in  1  synchronised IOW# active (level, high=active)
- io_addr  in  ADDR_W  byte offset within window
- sbhe_n  in  1  synchronised SBHE#
- isa_din  in  16  write data from ISA bus
- isa_dout  out  16  read data to ISA bus
- dout_oe_lo  out  1  drive D0-D7
- dout_oe_hi  out  1  drive D8-D15
- iocs16_n  out  1  IOCS16# (open-drain intent, low=16-bit)
- iochrdy  out  1  0=insert wait states
- reg_req  out  1  internal request, held until reg_ack
- reg_we  out  1  1=write
- reg_addr  out  ADDR_W-1  word address
- reg_be  out  2  byte enables {hi,lo}
- reg_wdata  out  16  internal write data
- reg_rdata  in  16  internal read data, valid with reg_ack
- reg_ack  in  1  single-cycle completion
- timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values:
  - Outputs: isa_dout=0, dout_oe_lo/hi=0, iocs16_n=1, iochrdy=1, reg_req=0, reg_we=0, reg_addr=0, reg_be=0, reg_wdata=0, timeout_err=0.
  - Internal: state IDLE, lo_pending=0, hi_valid=0.
- iocs16_n = ~(io_sel & enable_high_byte), combinational; 1 whenever enable_high_byte=0.
- Access start: rising edge of (io_rd|io_wr)&io_sel, detected in IDLE. enable_high_byte is sampled at the same edge.
  - iochrdy goes low the cycle after the edge unless the access completes without an internal request.
- States:
  - IDLE: on access start, go to FLUSH when a flush is needed, ACCESS when an internal access is needed, otherwise HOLD.
  - FLUSH: reg_req write with be=01, wdata={8'h00,lo_buf}, addr=lo_addr. On ack: clear lo_pending, go to ACCESS.
  - ACCESS: reg_req asserted until reg_ack. On ack: capture data, set iochrdy=1, go to HOLD.
  - HOLD: iochrdy=1; dout_oe held for reads; return to IDLE when io_rd and io_wr are both 0.
- AT mode:
  - be={~sbhe_n, ~io_addr[0]}.
  - Byte data stays on its natural lane.
  - No buffering: every access goes to ACCESS.
- XT mode: all data is on D0-D7 only, dout_oe_hi=0.
  - Even write: store lo_buf, set lo_pending with lo_addr; complete via HOLD with no wait state.
  - Odd write with lo_pending and same word address: be=11, wdata={din[7:0],lo_buf}; clears lo_pending.
  - Odd write without a match: be=10, wdata={din[7:0],8'h00}.
  - Even read: be=11; return low byte; latch high byte into hi_buf; set hi_valid for that word.
  - Odd read with hi_valid and same word: return hi_buf with no wait state; clear hi_valid.
  - Odd read without a match: be=10 internal read; return high byte.
- Flush rule (XT mode): any access while lo_pending that is not an odd write to lo_addr first goes through FLUSH. An even write to lo_addr also flushes the old byte first.
- hi_valid is cleared by any write to the same word, and by any access to a different word.
- A change of enable_high_byte seen at access start drops lo_pending and hi_valid without flushing.
- Timeout: counter runs in FLUSH/ACCESS and resets per request. On reaching ACK_TIMEOUT:
  - drop reg_req; pulse timeout_err;
  - reads return 16'hFFFF;
  - go to HOLD; a timed-out FLUSH still clears lo_pending.
- io_sel dropping mid-access does not abort; completion waits for the strobes to deassert.

Optional Feature:
- Macro ISA_WIDTH_STATS_EN.
- Defined: adds outputs stat_paired[15:0] (XT paired writes), stat_flush[15:0] (flushes) and stat_tmo[15:0] (timeouts). These are saturating counters, reset to 0.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- AT mode, write 16'hBEEF to offset 2 with sbhe_n=0 -> iocs16_n=0; one reg_req with addr=1, be=11, wdata=BEEF; iochrdy low until ack.
- XT mode, write 8'h34 to offset 4, then 8'h12 to offset 5 -> first write completes with no reg_req; second issues addr=2, be=11, wdata=1234.
- XT mode, read offset 6 (reg_rdata=A55A) then offset 7 -> first returns 5A after one reg_req; second returns A5 with iochrdy never low and no reg_req.
- XT mode, write 8'h77 to offset 0, then read offset 8 -> FLUSH write addr=0, be=01, wdata=0077; then read of addr=4.
- reg_ack withheld for ACK_TIMEOUT cycles on a read -> timeout_err pulses once, isa_dout=FFFF, iochrdy returns to 1.
- Reset asserted during ACCESS -> reg_req=0, iochrdy=1, lo_pending cleared immediately.

Source files
------------

// File: rtl/isa_width_sequencer.sv
// ISA I/O cycle sequencer: AT 16-bit pass-through or XT byte pairing onto a 16-bit register bus.
// Optional saturating statistics counters when ISA_WIDTH_STATS_EN is defined.
module isa_width_sequencer #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_high_byte,
  input  logic              io_sel,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic              sbhe_n,
  input  logic [15:0]       isa_din,
  output logic [15:0]       isa_dout,
  output logic              dout_oe_lo,
  output logic              dout_oe_hi,
  output logic              iocs16_n,
  output logic              iochrdy,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-2:0] reg_addr,
  output logic [1:0]        reg_be,
  output logic [15:0]       reg_wdata,
  input  logic [15:0]       reg_rdata,
  input  logic              reg_ack,
  output logic              timeout_err
`ifdef ISA_WIDTH_STATS_EN
  ,
  output logic [15:0]       stat_paired,
  output logic [15:0]       stat_flush,
  output logic [15:0]       stat_tmo
`endif
);

  localparam int unsigned WA_W = ADDR_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ACCESS, S_HOLD} state_t;

  state_t            state;
  logic              strobe_q;
  logic              mode_q;
  logic              lo_pending;
  logic [WA_W-1:0]   lo_addr;
  logic [7:0]        lo_buf;
  logic              hi_valid;
  logic [WA_W-1:0]   hi_addr;
  logic [7:0]        hi_buf;
  logic              acc_need;
  logic              acc_rd;
  logic              acc_at;
  logic              acc_odd;
  logic              nxt_we;
  logic [WA_W-1:0]   nxt_addr;
  logic [1:0]        nxt_be;
  logic [15:0]       nxt_wdata;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              strobe;
  logic              start;
  logic              odd;
  logic [WA_W-1:0]   waddr;
  logic              mode_chg;
  logic              lo_live;
  logic              hi_live;
  logic              pair_hit;
  logic              hi_hit;
  logic              need_flush;
  logic              need_acc;
  logic [1:0]        acc_be;
  logic [15:0]       acc_wdata;
  logic [15:0]       rd_data;
  logic              rd_oe_lo;
  logic              rd_oe_hi;
  logic              tmo_hit;

  assign iocs16_n = ~(io_sel & enable_high_byte);

  // Access classification at cycle start; a slot-width change invalidates buffered bytes.
  always_comb begin
    waddr      = io_addr[ADDR_W-1:1];
    odd        = io_addr[0];
    strobe     = (io_rd | io_wr) & io_sel;
    start      = (state == S_IDLE) & strobe & ~strobe_q;
    mode_chg   = enable_high_byte ^ mode_q;
    lo_live    = lo_pending & ~mode_chg & ~enable_high_byte;
    hi_live    = hi_valid & ~mode_chg & ~enable_high_byte;
    pair_hit   = lo_live & io_wr & odd & (lo_addr == waddr);
    hi_hit     = hi_live & ~io_wr & odd & (hi_addr == waddr) & ~lo_live;
    need_flush = lo_live & ~pair_hit;
    need_acc   = enable_high_byte | ~((io_wr & ~odd) | hi_hit);
    acc_be     = 2'b11;
    acc_wdata  = 16'h0000;
    if (enable_high_byte) begin
      acc_be    = {~sbhe_n, ~odd};
      acc_wdata = isa_din;
    end else if (io_wr) begin
      if (pair_hit) begin
        acc_be    = 2'b11;
        acc_wdata = {isa_din[7:0], lo_buf};
      end else if (odd) begin
        acc_be    = 2'b10;
        acc_wdata = {isa_din[7:0], 8'h00};
      end else begin
        acc_be    = 2'b01;
        acc_wdata = {8'h00, isa_din[7:0]};
      end
    end else begin
      acc_be = odd ? 2'b10 : 2'b11;
    end
    rd_data  = acc_at ? reg_rdata : {8'h00, (acc_odd ? reg_rdata[15:8] : reg_rdata[7:0])};
    rd_oe_lo = acc_at ? nxt_be[0] : 1'b1;
    rd_oe_hi = acc_at & nxt_be[1];
    tmo_hit  = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      strobe_q    <= 1'b0;
      mode_q      <= 1'b0;
      lo_pending  <= 1'b0;
      lo_addr     <= '0;
      lo_buf      <= 8'h00;
      hi_valid    <= 1'b0;
      hi_addr     <= '0;
      hi_buf      <= 8'h00;
      acc_need    <= 1'b0;
      acc_rd      <= 1'b0;
      acc_at      <= 1'b0;
      acc_odd     <= 1'b0;
      nxt_we      <= 1'b0;
      nxt_addr    <= '0;
      nxt_be      <= 2'b00;
      nxt_wdata   <= 16'h0000;
      tmo_cnt     <= '0;
      isa_dout    <= 16'h0000;
      dout_oe_lo  <= 1'b0;
      dout_oe_hi  <= 1'b0;
      iochrdy     <= 1'b1;
      reg_req     <= 1'b0;
      reg_we      <= 1'b0;
      reg_addr    <= '0;
      reg_be      <= 2'b00;
      reg_wdata   <= 16'h0000;
      timeout_err <= 1'b0;
    end else begin
      strobe_q    <= strobe;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Pending low byte is handed to the flush payload here, so lo_buf can take a new byte.
            mode_q     <= enable_high_byte;
            hi_valid   <= 1'b0;
            hi_addr    <= waddr;
            lo_pending <= ~enable_high_byte & io_wr & ~odd;
            if (~enable_high_byte & io_wr & ~odd) begin
              lo_buf  <= isa_din[7:0];
              lo_addr <= waddr;
            end
            acc_need  <= need_acc;
            acc_rd    <= ~io_wr;
            acc_at    <= enable_high_byte;
            acc_odd   <= odd;
            nxt_we    <= io_wr;
            nxt_addr  <= waddr;
            nxt_be    <= acc_be;
            nxt_wdata <= acc_wdata;
            tmo_cnt   <= '0;
            if (need_flush) begin
              state     <= S_FLUSH;
              reg_req   <= 1'b1;
              reg_we    <= 1'b1;
              reg_addr  <= lo_addr;
              reg_be    <= 2'b01;
              reg_wdata <= {8'h00, lo_buf};
              iochrdy   <= 1'b0;
            end else if (need_acc) begin
              state     <= S_ACCESS;
              reg_req   <= 1'b1;
              reg_we    <= io_wr;
              reg_addr  <= waddr;
              reg_be    <= acc_be;
              reg_wdata <= acc_wdata;
              iochrdy   <= 1'b0;
            end else begin
              state <= S_HOLD;
              if (hi_hit) begin
                isa_dout   <= {8'h00, hi_buf};
                dout_oe_lo <= 1'b1;
                dout_oe_hi <= 1'b0;
              end
            end
          end
        end
        S_FLUSH: begin
          if (reg_ack) begin
            reg_req <= 1'b0;
            tmo_cnt <= '0;
            if (acc_need) begin
              state <= S_ACCESS;
            end else begin
              state   <= S_HOLD;
              iochrdy <= 1'b1;
            end
          end else if (tmo_hit) begin
            reg_req     <= 1'b0;
            timeout_err <= 1'b1;
            iochrdy     <= 1'b1;
            state       <= S_HOLD;
            if (acc_rd) begin
              isa_dout   <= 16'hFFFF;
              dout_oe_lo <= rd_oe_lo;
              dout_oe_hi <= rd_oe_hi;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_ACCESS: begin
          // Entered from FLUSH with the request dropped for one cycle before the real access.
          if (!reg_req) begin
            reg_req   <= 1'b1;
            reg_we    <= nxt_we;
            reg_addr  <= nxt_addr;
            reg_be    <= nxt_be;
            reg_wdata <= nxt_wdata;
            tmo_cnt   <= '0;
          end else if (reg_ack) begin
            reg_req <= 1'b0;
            iochrdy <= 1'b1;
            state   <= S_HOLD;
            if (acc_rd) begin
              isa_dout   <= rd_data;
              dout_oe_lo <= rd_oe_lo;
              dout_oe_hi <= rd_oe_hi;
              if (!acc_at && !acc_odd) begin
                hi_buf   <= reg_rdata[15:8];
                hi_valid <= 1'b1;
              end
            end
          end else if (tmo_hit) begin
            reg_req     <= 1'b0;
            timeout_err <= 1'b1;
            iochrdy     <= 1'b1;
            state       <= S_HOLD;
            if (acc_rd) begin
              isa_dout   <= 16'hFFFF;
              dout_oe_lo <= rd_oe_lo;
              dout_oe_hi <= rd_oe_hi;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_HOLD: begin
          if (!io_rd && !io_wr) begin
            state      <= S_IDLE;
            dout_oe_lo <= 1'b0;
            dout_oe_hi <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ISA_WIDTH_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_paired <= 16'h0000;
      stat_flush  <= 16'h0000;
      stat_tmo    <= 16'h0000;
    end else begin
      if (start && pair_hit && stat_paired != 16'hFFFF) stat_paired <= stat_paired + 16'd1;
      if (start && need_flush && stat_flush != 16'hFFFF) stat_flush <= stat_flush + 16'd1;
      if (timeout_err && stat_tmo != 16'hFFFF) stat_tmo <= stat_tmo + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_isa_width_sequencer.sv
// Randomized bench for isa_width_sequencer against a transaction-level model and a memory-backed register slave.
module tb_isa_width_sequencer;

  localparam int unsigned ACK_TIMEOUT = 255;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } xact_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_high_byte = 1'b0;
  logic        io_sel = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [3:0]  io_addr = 4'h0;
  logic        sbhe_n = 1'b1;
  logic [15:0] isa_din = 16'h0000;
  logic [15:0] isa_dout;
  logic        dout_oe_lo;
  logic        dout_oe_hi;
  logic        iocs16_n;
  logic        iochrdy;
  logic        reg_req;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [1:0]  reg_be;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'h0000;
  logic        reg_ack = 1'b0;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  logic [15:0] slv_mem [8];
  logic [15:0] m_mem [8];
  xact_t       obs_q[$];
  xact_t       exp_q[$];
  bit          hold_ack = 1'b0;
  int          dly = 0;
  int          req_cycles = 0;
  int          tmo_pulses = 0;

  bit          m_mode = 1'b0;
  bit          m_lo_pend = 1'b0;
  logic [2:0]  m_lo_word = 3'd0;
  logic [7:0]  m_lo_byte = 8'h00;
  bit          m_hi_valid = 1'b0;
  logic [2:0]  m_hi_word = 3'd0;
  logic [7:0]  m_hi_byte = 8'h00;

  isa_width_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable_high_byte(enable_high_byte), .io_sel(io_sel),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .sbhe_n(sbhe_n), .isa_din(isa_din),
    .isa_dout(isa_dout), .dout_oe_lo(dout_oe_lo), .dout_oe_hi(dout_oe_hi), .iocs16_n(iocs16_n),
    .iochrdy(iochrdy), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_be(reg_be),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Register slave: random ack latency, records every completed request.
  always @(negedge clk) begin
    xact_t x;
    if (reg_req) req_cycles++;
    if (timeout_err) tmo_pulses++;
    if (reg_ack) begin
      reg_ack   = 1'b0;
      reg_rdata = 16'($urandom);
    end else if (rst_n && reg_req && !hold_ack) begin
      if (dly == 0) begin
        x.we = reg_we; x.addr = reg_addr; x.be = reg_be; x.wdata = reg_wdata;
        obs_q.push_back(x);
        reg_rdata = slv_mem[reg_addr];
        if (reg_we && reg_be[0]) slv_mem[reg_addr][7:0]  = reg_wdata[7:0];
        if (reg_we && reg_be[1]) slv_mem[reg_addr][15:8] = reg_wdata[15:8];
        reg_ack = 1'b1;
        dly = $urandom_range(0, 3);
      end else begin
        dly--;
      end
    end
  end

  task automatic push_x(input bit we, input logic [2:0] ad, input logic [1:0] be, input logic [15:0] wd);
    xact_t x;
    x.we = we; x.addr = ad; x.be = be; x.wdata = wd;
    exp_q.push_back(x);
    if (we && be[0]) m_mem[ad][7:0]  = wd[7:0];
    if (we && be[1]) m_mem[ad][15:8] = wd[15:8];
  endtask

  // Reference: expected internal transactions, read value and wait-state flag for one host cycle.
  task automatic model_op(input bit at, input bit wr, input logic [3:0] a, input logic [15:0] d,
                          input bit sb_n, output logic [15:0] rd, output bit wt);
    logic [2:0] w;
    bit odd, hit;
    w = a[3:1]; odd = a[0]; rd = 16'h0000; wt = 1'b0;
    if (at != m_mode) begin m_lo_pend = 1'b0; m_hi_valid = 1'b0; end
    m_mode = at;
    if (at) begin
      push_x(wr, w, {~sb_n, ~odd}, d);
      if (!wr) rd = m_mem[w];
      wt = 1'b1;
    end else begin
      hit = !wr && odd && m_hi_valid && (m_hi_word == w);
      if (m_lo_pend && !(wr && odd && w == m_lo_word)) begin
        push_x(1'b1, m_lo_word, 2'b01, {8'h00, m_lo_byte});
        m_lo_pend = 1'b0;
        wt = 1'b1;
      end
      if (wr && !odd) begin
        m_lo_pend = 1'b1; m_lo_word = w; m_lo_byte = d[7:0];
      end else if (wr) begin
        if (m_lo_pend) begin
          push_x(1'b1, w, 2'b11, {d[7:0], m_lo_byte});
          m_lo_pend = 1'b0;
        end else begin
          push_x(1'b1, w, 2'b10, {d[7:0], 8'h00});
        end
        wt = 1'b1;
      end else if (!odd) begin
        push_x(1'b0, w, 2'b11, 16'h0000);
        rd = {8'h00, m_mem[w][7:0]};
        wt = 1'b1;
      end else if (hit) begin
        rd = {8'h00, m_hi_byte};
      end else begin
        push_x(1'b0, w, 2'b10, 16'h0000);
        rd = {8'h00, m_mem[w][15:8]};
        wt = 1'b1;
      end
      if (hit || (wr && w == m_hi_word) || (w != m_hi_word)) m_hi_valid = 1'b0;
      if (!wr && !odd) begin m_hi_valid = 1'b1; m_hi_word = w; m_hi_byte = m_mem[w][15:8]; end
    end
  endtask

  task automatic isa_cycle(input bit wr, input logic [3:0] a, input logic [15:0] d, input bit sb_n,
                           output logic [15:0] rd, output bit waited, output bit oel, output bit oeh,
                           output bit cs);
    int n;
    @(negedge clk);
    io_addr = a; isa_din = d; sbhe_n = sb_n; io_sel = 1'b1; io_wr = wr; io_rd = !wr;
    waited = 1'b0;
    @(negedge clk);
    cs = iocs16_n;
    n = 0;
    while (!iochrdy && n < 600) begin
      waited = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("iochrdy_bound", 32'(iochrdy), 32'd1);
    rd = isa_dout; oel = dout_oe_lo; oeh = dout_oe_hi;
    @(negedge clk);
    io_rd = 1'b0; io_wr = 1'b0; io_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("oe_release", 32'({dout_oe_hi, dout_oe_lo}), 32'd0);
  endtask

  task automatic run_op(input bit at, input bit wr, input logic [3:0] a, input logic [15:0] d, input bit sb_n);
    logic [15:0] exp_rd, rd;
    bit exp_wait, waited, oel, oeh, cs;
    xact_t o, e;
    enable_high_byte = at;
    model_op(at, wr, a, d, sb_n, exp_rd, exp_wait);
    isa_cycle(wr, a, d, sb_n, rd, waited, oel, oeh, cs);
    check("iocs16_n", 32'(cs), 32'(!at));
    check("wait_state", 32'(waited), 32'(exp_wait));
    if (!wr) begin
      if (at) begin
        check("rd16", 32'(rd), 32'(exp_rd));
        check("oe_at", 32'({oeh, oel}), 32'({~sb_n, ~a[0]}));
      end else begin
        check("rd8", 32'(rd[7:0]), 32'(exp_rd[7:0]));
        check("oe_xt", 32'({oeh, oel}), 32'd1);
      end
    end
    check("req_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("req_we", 32'(o.we), 32'(e.we));
      check("req_addr", 32'(o.addr), 32'(e.addr));
      check("req_be", 32'(o.be), 32'(e.be));
      if (e.we) check("req_wdata", 32'(o.wdata), 32'(e.wdata));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, v;
    bit waited, oel, oeh, cs, at, wr, sb;
    logic [3:0] a;
    int r0, t0;

    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      slv_mem[i] = v;
      m_mem[i] = v;
    end

    repeat (3) @(negedge clk);
    check("rst_dout", 32'(isa_dout), 32'd0);
    check("rst_oe", 32'({dout_oe_hi, dout_oe_lo}), 32'd0);
    check("rst_cs16_rdy", 32'({iocs16_n, iochrdy}), 32'd3);
    check("rst_req", 32'({reg_req, reg_we, reg_be, timeout_err}), 32'd0);
    check("rst_addr_wdata", 32'({reg_addr, reg_wdata}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // AT native 16-bit write
    run_op(1'b1, 1'b1, 4'd2, 16'hBEEF, 1'b0);
    // XT byte pairing of a write
    run_op(1'b0, 1'b1, 4'd4, 16'h0034, 1'b1);
    run_op(1'b0, 1'b1, 4'd5, 16'h0012, 1'b1);
    // XT read with buffered high byte
    slv_mem[3] = 16'hA55A; m_mem[3] = 16'hA55A;
    run_op(1'b0, 1'b0, 4'd6, 16'h0000, 1'b1);
    run_op(1'b0, 1'b0, 4'd7, 16'h0000, 1'b1);
    // XT pending low byte flushed ahead of a read elsewhere
    run_op(1'b0, 1'b1, 4'd0, 16'h0077, 1'b1);
    run_op(1'b0, 1'b0, 4'd8, 16'h0000, 1'b1);

    // Ack withheld on an AT read
    hold_ack = 1'b1;
    r0 = req_cycles; t0 = tmo_pulses;
    enable_high_byte = 1'b1;
    isa_cycle(1'b0, 4'd0, 16'h0000, 1'b0, rd, waited, oel, oeh, cs);
    check("tmo_pulse", 32'(tmo_pulses - t0), 32'd1);
    check("tmo_dout", 32'(rd), 32'hFFFF);
    check("tmo_req_cycles", 32'(req_cycles - r0), 32'(ACK_TIMEOUT));
    check("tmo_waited", 32'(waited), 32'd1);
    check("tmo_rdy", 32'(iochrdy), 32'd1);
    check("tmo_noack", 32'(obs_q.size()), 32'd0);
    hold_ack = 1'b0;
    m_mode = 1'b1; m_lo_pend = 1'b0; m_hi_valid = 1'b0;
    obs_q.delete(); exp_q.delete();

    // Reset while an internal request is outstanding
    run_op(1'b0, 1'b1, 4'd2, 16'h0055, 1'b1);
    hold_ack = 1'b1;
    @(negedge clk);
    io_addr = 4'd9; io_sel = 1'b1; io_rd = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_req", 32'({reg_req, reg_be}), 32'b101);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(reg_req), 32'd0);
    check("rst_mid_rdy", 32'(iochrdy), 32'd1);
    @(negedge clk);
    io_rd = 1'b0; io_sel = 1'b0; hold_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 1'b0; m_lo_pend = 1'b0; m_hi_valid = 1'b0;
    obs_q.delete(); exp_q.delete();
    run_op(1'b0, 1'b1, 4'd3, 16'h0066, 1'b1);

    // Randomized traffic with occasional slot-width flips
    at = 1'b0;
    a = 4'd0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) at = ~at;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a = {a[3:1], 1'b1};
      else a = 4'($urandom);
      sb = (at && a[0]) ? 1'b0 : 1'($urandom_range(0, 1));
      run_op(at, wr, a, 16'($urandom), sb);
    end
    check("tmo_total", 32'(tmo_pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
